pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 16, which sets the width of the measurement counters and outputs.
REQ-002 SHALL have parameter TIMEOUT, default 50000, which is the number of clk_i cycles without a rising edge after which the signal is declared lost; the legal range is 2 <= TIMEOUT <= 2^CNT_W-1.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk_i  input  1  system clock; all state updates on its rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 pwm_i  input  1  external PWM waveform, asynchronous to clk_i.
REQ-007 ena_i  input  1  capture enable; low synchronously holds the block idle.
REQ-008 high_o  output  CNT_W  high time of the last complete period, in clk_i cycles.
REQ-009 period_o  output  CNT_W  rise-to-rise time of the last complete period, in clk_i cycles.
REQ-010 valid_o  output  1  one-cycle strobe: high_o and period_o were updated this cycle.
REQ-011 timeout_o  output  1  level; 1 means no valid measurement is current (signal lost, disabled, or never seen).

Function
REQ-012 SHALL pass pwm_i through a 2-flop synchronizer (s1, s2), register s2 into s2_d, and define rise = s2 & ~s2_d and fall = ~s2 & s2_d.
REQ-013 SHALL implement the FSM states IDLE, HIGH and LOW, with IDLE as the reset state.
REQ-014 IDLE: on rise -> HIGH with period_cnt=1; fall is ignored; no output update.
REQ-015 HIGH: each cycle without fall -> period_cnt+1; on fall -> latch high_cnt=period_cnt, period_cnt+1, move to LOW.
REQ-016 LOW: each cycle without rise -> period_cnt+1; on rise -> period_o=period_cnt, high_o=high_cnt, valid_o=1 for exactly one cycle, timeout_o=0, period_cnt=1, move to HIGH.
REQ-017 With the block in HIGH or LOW, if period_cnt==TIMEOUT and there is no rise this cycle: -> IDLE, timeout_o=1, period_cnt=0, no valid_o; high_o and period_o SHALL hold their values.
REQ-018 A rise in the same cycle that period_cnt==TIMEOUT SHALL win and produce a valid measurement with period_o=TIMEOUT.
REQ-019 period_cnt SHALL saturate at 2^CNT_W-1 and never wrap; because TIMEOUT is at most this value, the timeout always fires first.
REQ-020 Latency: if pwm_i is first sampled high at clock edge k (with the previous samples low), valid_o SHALL be high in the cycle after edge k+2.
REQ-021 The first valid_o SHALL occur only after two rises have been seen, so a partial first period is never reported.
REQ-022 A constant-low or constant-high pwm_i SHALL give timeout_o=1 at most TIMEOUT cycles after the last rise, with no valid_o.
REQ-023 ena_i=0 SHALL synchronously force: state IDLE, period_cnt=0, high_cnt=0, valid_o=0, timeout_o=1; high_o and period_o hold; the synchronizer keeps running.
REQ-024 When ena_i rises, the block SHALL restart from IDLE, and the next valid_o requires two fresh rises.
REQ-025 All outputs SHALL be driven directly from registers.

Reset
REQ-026 rst_ni=0 SHALL asynchronously clear s1, s2, s2_d, period_cnt, high_cnt, high_o, period_o and valid_o to 0, set timeout_o to 1, and set the state to IDLE.
REQ-027 Reset asserted mid-period SHALL discard the partial measurement; after release, behaviour is identical to power-up.

Verification (CNT_W=16, TIMEOUT=1000, ena_i=1 unless stated)
REQ-028 Reset -> high_o=0, period_o=0, valid_o=0, timeout_o=1; 5 cycles of pwm_i low after release leave all outputs unchanged.
REQ-029 pwm_i repeating 30 cycles high / 70 cycles low -> first valid_o 2 cycles after the second rise sample, with high_o=30, period_o=100, timeout_o=0; then exactly one valid_o every 100 cycles.
REQ-030 After a valid run, pwm_i held high -> timeout_o=1 exactly 1000 cycles after the last rise was detected, no valid_o, and high_o=30 and period_o=100 retained.
REQ-031 Rise arriving exactly when period_cnt==1000 (10 high / 990 low) -> valid_o with period_o=1000, high_o=10, timeout_o=0.
REQ-032 ena_i driven low for 3 cycles mid-high-phase, then high -> timeout_o=1 at once; the next valid_o follows the second subsequent rise with correct values.
REQ-033 rst_ni pulsed low during the LOW phase -> reset values at once; the next valid_o needs two rises after release.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture
//   Measures the high time and the rise-to-rise period of an external PWM
//   waveform in clk_i cycles. The waveform is synchronised, its edges are
//   detected, and a small IDLE/HIGH/LOW state machine counts cycles between
//   edges. A new measurement is published (with a one-cycle valid_o strobe)
//   only once a full period, from one rise to the next, has been seen.
//   If no rise arrives within TIMEOUT cycles, the signal is declared lost.
//
// Parameters
//   CNT_W    width of the measurement counters and outputs
//   TIMEOUT  clk_i cycles without a rise before the signal is declared lost
//            (2 <= TIMEOUT <= 2^CNT_W-1)
//
// Ports
//   clk_i      in   1      system clock, rising edge
//   rst_ni     in   1      asynchronous active-low reset
//   pwm_i      in   1      PWM waveform, asynchronous to clk_i
//   ena_i      in   1      capture enable; low holds the block idle
//   high_o     out  CNT_W  high time of the last complete period
//   period_o   out  CNT_W  rise-to-rise time of the last complete period
//   valid_o    out  1      one-cycle strobe: high_o/period_o just updated
//   timeout_o  out  1      no valid measurement is current

module pwm_capture #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pwm_i,
  input  logic             ena_i,
  output logic [CNT_W-1:0] high_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s1;
  logic             s2;
  logic             s2_d;
  logic             rise;
  logic             fall;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] period_cnt_n;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] high_cnt_n;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] high_n;
  logic [CNT_W-1:0] period_n;
  logic             valid_n;
  logic             timeout_n;
  logic             timeout_hit;

  // Two-flop synchroniser plus one delay stage for edge detection. It keeps
  // running while ena_i is low so that re-enabling never sees a stale edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= pwm_i;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign rise = s2 & ~s2_d;
  assign fall = ~s2 & s2_d;

  // Saturating increment; TIMEOUT never exceeds CNT_MAX, so the timeout
  // always fires before saturation matters.
  assign cnt_inc = (period_cnt == CNT_MAX) ? period_cnt : period_cnt + CNT_ONE;

  // A rise in the very cycle the count reaches TIMEOUT still counts as a
  // valid period, so the timeout is suppressed whenever a rise is present.
  assign timeout_hit = (period_cnt == TIMEOUT_VAL) && !rise;

  // State register together with every counter and output register, so all
  // outputs come straight from flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      period_cnt <= '0;
      high_cnt   <= '0;
      high_o     <= '0;
      period_o   <= '0;
      valid_o    <= 1'b0;
      timeout_o  <= 1'b1;
    end else begin
      state      <= state_n;
      period_cnt <= period_cnt_n;
      high_cnt   <= high_cnt_n;
      high_o     <= high_n;
      period_o   <= period_n;
      valid_o    <= valid_n;
      timeout_o  <= timeout_n;
    end
  end

  // Next-state and next-output logic. The published measurement holds its
  // value on timeout or disable; only a completed period overwrites it.
  always_comb begin
    state_n      = state;
    period_cnt_n = period_cnt;
    high_cnt_n   = high_cnt;
    high_n       = high_o;
    period_n     = period_o;
    valid_n      = 1'b0;
    timeout_n    = timeout_o;

    if (!ena_i) begin
      state_n      = IDLE;
      period_cnt_n = '0;
      high_cnt_n   = '0;
      timeout_n    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // The first rise only starts a period; a fall here is meaningless.
          if (rise) begin
            state_n      = HIGH;
            period_cnt_n = CNT_ONE;
          end
        end

        HIGH: begin
          if (timeout_hit) begin
            state_n      = IDLE;
            period_cnt_n = '0;
            timeout_n    = 1'b1;
          end else if (fall) begin
            state_n      = LOW;
            high_cnt_n   = period_cnt;
            period_cnt_n = cnt_inc;
          end else begin
            period_cnt_n = cnt_inc;
          end
        end

        LOW: begin
          if (rise) begin
            state_n      = HIGH;
            period_n     = period_cnt;
            high_n       = high_cnt;
            valid_n      = 1'b1;
            timeout_n    = 1'b0;
            period_cnt_n = CNT_ONE;
          end else if (timeout_hit) begin
            state_n      = IDLE;
            period_cnt_n = '0;
            timeout_n    = 1'b1;
          end else begin
            period_cnt_n = cnt_inc;
          end
        end

        default: begin
          state_n      = IDLE;
          period_cnt_n = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture
//   Directed testbench for pwm_capture with CNT_W=16, TIMEOUT=1000.
//   Inputs change on the falling clock edge; outputs are sampled on the
//   falling edge after each rising edge. Every expected value below is
//   derived by hand from the waveform being driven: a level driven before
//   rising edge k is detected as an edge at rising edge k+2.

module tb_pwm_capture;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  logic             clk_i;
  logic             rst_ni;
  logic             pwm_i;
  logic             ena_i;
  logic [CNT_W-1:0] high_o;
  logic [CNT_W-1:0] period_o;
  logic             valid_o;
  logic             timeout_o;

  int tests_run;
  int tests_failed;
  int cyc;
  int valid_cnt;
  int last_valid_cyc;
  int prev_valid_cyc;
  int valid_mark;

  pwm_capture #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .pwm_i     (pwm_i),
    .ena_i     (ena_i),
    .high_o    (high_o),
    .period_o  (period_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One comparison: counts it, and reports tag/observed/expected on failure.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Hold pwm_i at 'level' for n clock cycles, tallying every valid_o strobe
  // seen at the falling-edge sample points.
  task automatic apply_stimulus(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_i = level;
      @(posedge clk_i);
      @(negedge clk_i);
      if (valid_o === 1'b1) begin
        valid_cnt++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      cyc++;
    end
  endtask

  // Wait n cycles with whatever inputs are currently applied.
  task automatic idle_cycles(input int n);
    apply_stimulus(pwm_i, n);
  endtask

  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    cyc            = 0;
    valid_cnt      = 0;
    last_valid_cyc = 0;
    prev_valid_cyc = 0;
    pwm_i          = 1'b0;
    ena_i          = 1'b1;
    rst_ni         = 1'b0;

    // Reset values
    repeat (3) @(negedge clk_i);
    check_output("rst_high",    high_o,    0);
    check_output("rst_period",  period_o,  0);
    check_output("rst_valid",   valid_o,   0);
    check_output("rst_timeout", timeout_o, 1);
    rst_ni = 1'b1;

    // Five quiet cycles change nothing
    apply_stimulus(1'b0, 5);
    check_output("quiet_high",    high_o,    0);
    check_output("quiet_period",  period_o,  0);
    check_output("quiet_timeout", timeout_o, 1);
    check_output("quiet_nvalid",  valid_cnt, 0);

    // 30 high / 70 low: first period is partial-safe, no report yet
    apply_stimulus(1'b1, 30);
    apply_stimulus(1'b0, 70);
    check_output("p1_nvalid", valid_cnt, 0);
    // Second rise: sampled at edge k, strobe appears after edge k+2
    apply_stimulus(1'b1, 2);
    check_output("p2_early_nvalid", valid_cnt, 0);
    apply_stimulus(1'b1, 1);
    check_output("p2_valid",   valid_o,   1);
    check_output("p2_high",    high_o,    30);
    check_output("p2_period",  period_o,  100);
    check_output("p2_timeout", timeout_o, 0);
    apply_stimulus(1'b1, 1);
    check_output("p2_strobe_len", valid_o, 0);
    apply_stimulus(1'b1, 26);
    apply_stimulus(1'b0, 70);
    check_output("p2_nvalid", valid_cnt, 1);
    // Three more periods: one strobe each, 100 cycles apart
    for (int p = 0; p < 3; p++) begin
      apply_stimulus(1'b1, 30);
      apply_stimulus(1'b0, 70);
    end
    check_output("p5_nvalid",   valid_cnt, 4);
    check_output("p5_interval", last_valid_cyc - prev_valid_cyc, 100);

    // Hold high: the opening rise completes one more period, then the
    // timeout lands exactly 1000 edges after that rise was detected.
    valid_mark = valid_cnt;
    apply_stimulus(1'b1, 1002);
    check_output("hold_pre_timeout", timeout_o, 0);
    apply_stimulus(1'b1, 1);
    check_output("hold_timeout", timeout_o, 1);
    check_output("hold_high",    high_o,    30);
    check_output("hold_period",  period_o,  100);
    apply_stimulus(1'b1, 5);
    check_output("hold_nvalid",  valid_cnt - valid_mark, 1);
    check_output("hold_timeout2", timeout_o, 1);

    // 10 high / 990 low: rise lands exactly when the count equals TIMEOUT
    apply_stimulus(1'b0, 5);
    valid_mark = valid_cnt;
    apply_stimulus(1'b1, 10);
    apply_stimulus(1'b0, 990);
    check_output("edge_pre_timeout", timeout_o, 1);
    check_output("edge_pre_nvalid",  valid_cnt - valid_mark, 0);
    apply_stimulus(1'b1, 3);
    check_output("edge_valid",   valid_o,   1);
    check_output("edge_period",  period_o,  1000);
    check_output("edge_high",    high_o,    10);
    check_output("edge_timeout", timeout_o, 0);

    // 10 high / 991 low: one cycle too late, so the timeout wins
    apply_stimulus(1'b1, 7);
    apply_stimulus(1'b0, 991);
    check_output("late_pre_timeout", timeout_o, 0);
    apply_stimulus(1'b1, 2);
    check_output("late_timeout", timeout_o, 1);
    apply_stimulus(1'b1, 1);
    check_output("late_nvalid",  valid_cnt - valid_mark, 1);
    check_output("late_high",    high_o,   10);
    check_output("late_period",  period_o, 1000);

    // Establish a fresh 10/50 measurement, then disable mid-high-phase
    apply_stimulus(1'b1, 7);
    apply_stimulus(1'b0, 40);
    apply_stimulus(1'b1, 3);
    check_output("pre_ena_valid",  valid_o,   1);
    check_output("pre_ena_high",   high_o,    10);
    check_output("pre_ena_period", period_o,  50);
    check_output("pre_ena_timeout", timeout_o, 0);
    apply_stimulus(1'b1, 5);
    valid_mark = valid_cnt;
    ena_i = 1'b0;
    apply_stimulus(1'b1, 1);
    check_output("dis_timeout", timeout_o, 1);
    check_output("dis_high",    high_o,    10);
    check_output("dis_period",  period_o,  50);
    apply_stimulus(1'b1, 2);
    ena_i = 1'b1;
    // Re-enabled while high: no edge, then two fresh rises for a report
    apply_stimulus(1'b1, 10);
    apply_stimulus(1'b0, 20);
    apply_stimulus(1'b1, 20);
    apply_stimulus(1'b0, 30);
    check_output("ena_first_nvalid", valid_cnt - valid_mark, 0);
    check_output("ena_timeout_held", timeout_o, 1);
    apply_stimulus(1'b1, 3);
    check_output("ena_valid",   valid_o,   1);
    check_output("ena_high",    high_o,    20);
    check_output("ena_period",  period_o,  50);
    check_output("ena_timeout", timeout_o, 0);

    // Reset pulse during the LOW phase takes effect without a clock edge
    apply_stimulus(1'b1, 17);
    apply_stimulus(1'b0, 10);
    rst_ni = 1'b0;
    #1;
    check_output("mid_rst_high",    high_o,    0);
    check_output("mid_rst_period",  period_o,  0);
    check_output("mid_rst_valid",   valid_o,   0);
    check_output("mid_rst_timeout", timeout_o, 1);
    apply_stimulus(1'b0, 2);
    rst_ni = 1'b1;
    valid_mark = valid_cnt;
    apply_stimulus(1'b0, 5);
    apply_stimulus(1'b1, 15);
    apply_stimulus(1'b0, 25);
    check_output("post_rst_nvalid", valid_cnt - valid_mark, 0);
    apply_stimulus(1'b1, 3);
    check_output("post_rst_valid",   valid_o,   1);
    check_output("post_rst_high",    high_o,    15);
    check_output("post_rst_period",  period_o,  40);
    check_output("post_rst_timeout", timeout_o, 0);
    idle_cycles(1);
    check_output("post_rst_strobe_len", valid_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
